hpdcache_refill_beat_arbiter: RTL and testbench
===============================================

Name: hpdcache_refill_beat_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares one narrow refill beat channel among N_REQ requesters.
- Each requester is a downsizing refill buffer presenting valid/ready/data/last beats.
- Once a requester wins, it keeps the channel until its last beat transfers, so beats of different cache lines never interleave.
- Sits between the per-source refill downsizers and the cache refill write port.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- DATA_WIDTH, 64, width of one beat in bits; must be > 0.
- ID_WIDTH, (N_REQ > 1) ? $clog2(N_REQ) : 1, width of the requester index. Derived localparam, not overridable.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester beat valid.
- req_ready_o  out  N_REQ  per-requester beat accepted; one-hot or zero.
- req_data_i  in  N_REQ*DATA_WIDTH  beats, packed; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  N_REQ  marks the final beat of a requester's burst.
- out_valid_o  out  1  beat valid toward the refill port.
- out_ready_i  in  1  refill port accepts the beat.
- out_data_o  out  DATA_WIDTH  selected beat.
- out_last_o  out  1  selected beat is the last of its burst.
- out_first_o  out  1  selected beat is the first of its burst.
- out_id_o  out  ID_WIDTH  index of the selected requester.

Behaviour:
- State: fsm ∈ {IDLE, LOCKED}, owner_q (ID_WIDTH), rr_ptr_q (ID_WIDTH). All are async-reset to IDLE / 0 / 0.
- While rst_i is high:
  - out_valid_o=0, req_ready_o=0, out_first_o=0, out_last_o=0.
  - out_id_o=0, out_data_o=0.
- Winner selection:
  - IDLE: the winner is the first index with req_valid_i set, scanning rr_ptr_q, rr_ptr_q+1, … modulo N_REQ. Selection is combinational, zero-cycle latency.
  - LOCKED: the winner is owner_q, regardless of other valids.
- Output muxing:
  - out_valid_o = req_valid_i[winner].
  - out_data_o / out_last_o / out_id_o are taken from the winner.
  - out_first_o = out_valid_o & (fsm==IDLE).
  - When no requester is valid in IDLE: out_valid_o=0 and out_id_o=rr_ptr_q. out_data_o and out_last_o are don't-care but must be driven from requester rr_ptr_q.
- Ready and transfer:
  - req_ready_o[winner] = out_ready_i & out_valid_o; all other bits are 0.
  - No combinational path from out_ready_i to out_valid_o.
  - A transfer occurs when out_valid_o & out_ready_i.
- Transitions, evaluated only on a transfer:
  - IDLE, beat with last=1: stay IDLE; rr_ptr_q ← winner+1 (wrap from N_REQ-1 to 0).
  - IDLE, beat with last=0: go to LOCKED; owner_q ← winner.
  - LOCKED, beat with last=1: go to IDLE; rr_ptr_q ← owner_q+1 (wrap).
  - LOCKED, beat with last=0: stay LOCKED.
  - No transfer: all state holds.
- No lock in IDLE without a transfer: a grant shown while out_ready_i=0 may move to another requester next cycle if valids change.
- Owner bubbles: in LOCKED, if req_valid_i[owner_q] drops, out_valid_o=0. The channel stays owned; other requesters keep ready=0.
- Reset mid-burst: the burst is abandoned and the arbiter returns to IDLE with rr_ptr_q=0. Upstream buffers are reset by the same reset, so no partial-burst recovery is needed.
- N_REQ=1: the arbiter degenerates to a pass-through with first/last tracking. rr_ptr_q and owner_q stay 0.
- Assertions (disabled by HPDCACHE_ASSERT_OFF):
  - Error if N_REQ < 1, N_REQ > 16, or DATA_WIDTH = 0.
  - Runtime check that req_ready_o is one-hot or zero.
  - Runtime check that, while out_valid_o & !out_ready_i, out_data_o, out_last_o and out_id_o are stable in LOCKED.

Test Plan:
- N_REQ=4. Req0 sends 4 beats D0..D3 (last on D3), out_ready_i=1 → out_id_o=0 for 4 cycles; out_first_o only on D0; out_last_o only on D3; rr_ptr_q=1 afterwards.
- Req1 and req2 both valid with 2-beat bursts, rr_ptr_q=0 → req1's burst completes fully, then req2's. No interleave; ids 1,1,2,2.
- Req3 is mid-burst (LOCKED, beat 2 of 4) and out_ready_i is low for 3 cycles while req0 is valid → req3's data and id are held stable; req_ready_o=0; req0 is not granted until req3's last beat transfers.
- LOCKED on req2, then req_valid_i[2] drops for 2 cycles while req1 is valid → out_valid_o=0 for those cycles. Ownership is kept; req2 resumes and finishes before req1.
- All 4 requesters continuously send single-beat bursts (last=1), out_ready_i=1 → out_id_o sequence is 0,1,2,3,0,1; out_first_o and out_last_o are both 1 each cycle.
- Assert rst_i during beat 2 of a 4-beat req1 burst, then release with req0 and req1 valid → all outputs are 0 during reset; the first grant after reset is req0 (rr_ptr_q=0) with out_first_o=1.

Source files
------------

// File: rtl/hpdcache_refill_beat_arbiter.sv
// Refill beat arbiter: round-robin grant among N_REQ refill downsizers, held for a whole burst.
// Latency: zero cycles; the winner's beat passes combinationally to the refill port.
// Backpressure: out_ready_i reaches only the winner's ready; losers and a bubbling owner see ready=0.
module hpdcache_refill_beat_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 64,
   localparam int unsigned ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   output logic [N_REQ-1:0]              req_ready_o,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
   input  logic [N_REQ-1:0]              req_last_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_last_o,
   output logic                          out_first_o,
   output logic [ID_WIDTH-1:0]           out_id_o
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   owner_q, owner_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   win_idle;
   logic                  xfer;

   logic [DATA_WIDTH-1:0] data_arr [N_REQ];
   logic [2*N_REQ-1:0]    vld_dbl;
   logic [2*N_REQ-1:0]    vld_shift;
   logic [N_REQ-1:0]      vld_rot;
   logic [ID_WIDTH:0]     offs;
   logic [ID_WIDTH:0]     sum_raw;
   logic [ID_WIDTH:0]     sum_wrap;

   // Next index after idx, wrapping at the last requester.
   function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
      if (idx == ID_WIDTH'(N_REQ - 1)) return '0;
      return idx + ID_WIDTH'(1);
   endfunction

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // Winner: first valid requester at or after rr_ptr_q when idle, the burst owner when locked.
   always_comb begin
      vld_dbl   = {req_valid_i, req_valid_i};
      vld_shift = vld_dbl >> rr_ptr_q;
      vld_rot   = vld_shift[N_REQ-1:0];
      offs      = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (vld_rot[i]) offs = (ID_WIDTH+1)'(i);
      end
      sum_raw  = {1'b0, rr_ptr_q} + offs;
      sum_wrap = (sum_raw >= (ID_WIDTH+1)'(N_REQ)) ? sum_raw - (ID_WIDTH+1)'(N_REQ) : sum_raw;
      win_idle = sum_wrap[ID_WIDTH-1:0];
      winner   = (state_q == LOCKED) ? owner_q : win_idle;
   end

   // State register: FSM, burst owner and round-robin pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next state: only a transferred beat moves the FSM; the last beat releases the lock.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         case (state_q)
            IDLE: begin
               if (out_last_o) begin
                  rr_ptr_d = wrap_inc(winner);
               end else begin
                  state_d = LOCKED;
                  owner_d = winner;
               end
            end
            LOCKED: begin
               if (out_last_o) begin
                  state_d  = IDLE;
                  rr_ptr_d = wrap_inc(owner_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: mux the winner's beat, forced to zero while reset is asserted.
   always_comb begin
      out_valid_o = 1'b0;
      out_data_o  = '0;
      out_last_o  = 1'b0;
      out_id_o    = '0;
      out_first_o = 1'b0;
      req_ready_o = '0;
      xfer        = 1'b0;
      if (!rst_i) begin
         out_valid_o = req_valid_i[winner];
         out_data_o  = data_arr[winner];
         out_last_o  = req_last_i[winner];
         out_id_o    = winner;
         out_first_o = out_valid_o && (state_q == IDLE);
         xfer        = out_valid_o && out_ready_i;
         for (int k = 0; k < int'(N_REQ); k++) begin
            req_ready_o[k] = xfer && (winner == ID_WIDTH'(k));
         end
      end
   end

`ifndef HPDCACHE_ASSERT_OFF
   logic                  stall_q;
   logic [DATA_WIDTH-1:0] stall_data_q;
   logic                  stall_last_q;
   logic [ID_WIDTH-1:0]   stall_id_q;

   // Capture the beat presented during a locked stall for the stability check.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q      <= 1'b0;
         stall_data_q <= '0;
         stall_last_q <= 1'b0;
         stall_id_q   <= '0;
      end else begin
         stall_q      <= out_valid_o && !out_ready_i && (state_q == LOCKED);
         stall_data_q <= out_data_o;
         stall_last_q <= out_last_o;
         stall_id_q   <= out_id_o;
      end
   end

   // Parameter legality, one-hot ready, and a stalled locked beat must not change.
   always_ff @(posedge clk_i) begin
      assert (N_REQ >= 1 && N_REQ <= 16 && DATA_WIDTH > 0)
         else $error("illegal parameters N_REQ=%0d DATA_WIDTH=%0d", N_REQ, DATA_WIDTH);
      if (!rst_i) begin
         assert ($onehot0(req_ready_o))
            else $error("req_ready_o not one-hot: %b", req_ready_o);
         if (stall_q && state_q == LOCKED && out_valid_o) begin
            assert (out_data_o == stall_data_q && out_last_o == stall_last_q && out_id_o == stall_id_q)
               else $error("stalled locked beat changed");
         end
      end
   end
`endif

endmodule

// File: tb/tb_hpdcache_refill_beat_arbiter.sv
// Directed bench for the refill beat arbiter with N_REQ=4, DATA_WIDTH=64.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived per step from the arbitration rules.
module tb_hpdcache_refill_beat_arbiter;
   localparam int N_REQ = 4;
   localparam int DW    = 64;
   localparam int IDW   = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [N_REQ-1:0]      req_valid_i;
   logic [N_REQ-1:0]      req_ready_o;
   logic [N_REQ*DW-1:0]   req_data_i;
   logic [N_REQ-1:0]      req_last_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DW-1:0]         out_data_o;
   logic                  out_last_o;
   logic                  out_first_o;
   logic [IDW-1:0]        out_id_o;

   int checks = 0;
   int errors = 0;

   hpdcache_refill_beat_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_first_o (out_first_o),
      .out_id_o    (out_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Settle the combinational outputs, then compare the whole output set.
   task automatic expect_out(input string tag, input logic v, input logic [IDW-1:0] id,
                             input logic [DW-1:0] d, input logic f, input logic l,
                             input logic [N_REQ-1:0] rdy);
      #1;
      chk({tag, ".valid"}, 64'(out_valid_o), 64'(v));
      chk({tag, ".id"},    64'(out_id_o),    64'(id));
      chk({tag, ".data"},  64'(out_data_o),  64'(d));
      chk({tag, ".first"}, 64'(out_first_o), 64'(f));
      chk({tag, ".last"},  64'(out_last_o),  64'(l));
      chk({tag, ".ready"}, 64'(req_ready_o), 64'(rdy));
   endtask

   task automatic set_req(input int k, input logic v, input logic [DW-1:0] d, input logic l);
      req_valid_i[k]         = v;
      req_data_i[k*DW +: DW] = d;
      req_last_i[k]          = l;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset with every requester valid: all outputs must be zero.
      rst_i       = 1'b1;
      out_ready_i = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      for (int k = 0; k < N_REQ; k++) set_req(k, 1'b1, 64'hDEAD0 + 64'(k), 1'b1);
      #2;
      expect_out("reset", 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      rst_i = 1'b0;

      // Single-beat bursts from everyone: strict rotation 0,1,2,3,0,1.
      for (int k = 0; k < N_REQ; k++) set_req(k, 1'b1, 64'h500 + 64'(k), 1'b1);
      for (int i = 0; i < 6; i++) begin
         expect_out("rr", 1'b1, IDW'(i % 4), 64'h500 + 64'(i % 4), 1'b1, 1'b1, 4'(1 << (i % 4)));
         tick();
      end

      // Nothing valid: id shows the pointer (now 2), data/last from requester 2.
      req_valid_i = '0;
      expect_out("empty", 1'b0, 2'd2, 64'h502, 1'b0, 1'b1, 4'b0000);
      tick();

      // Req0 four-beat burst; pointer ends at 1.
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, 64'h1000 + 64'(i), (i == 3));
         expect_out("burst0", 1'b1, 2'd0, 64'h1000 + 64'(i), (i == 0), (i == 3), 4'b0001);
         tick();
      end
      req_valid_i = '0;

      // Grant without ready does not lock: it follows the valids.
      out_ready_i = 1'b0;
      set_req(0, 1'b1, 64'h2000, 1'b1);
      set_req(1, 1'b1, 64'h2100, 1'b1);
      expect_out("nolock_a", 1'b1, 2'd1, 64'h2100, 1'b1, 1'b1, 4'b0000);
      tick();
      req_valid_i[1] = 1'b0;
      expect_out("nolock_b", 1'b1, 2'd0, 64'h2000, 1'b1, 1'b1, 4'b0000);
      tick();
      req_valid_i = '0;
      out_ready_i = 1'b1;

      // Req1 and req2 two-beat bursts: ids 1,1,2,2, no interleave.
      set_req(1, 1'b1, 64'h3100, 1'b0);
      set_req(2, 1'b1, 64'h3200, 1'b0);
      expect_out("pair_1a", 1'b1, 2'd1, 64'h3100, 1'b1, 1'b0, 4'b0010);
      tick();
      set_req(1, 1'b1, 64'h3101, 1'b1);
      expect_out("pair_1b", 1'b1, 2'd1, 64'h3101, 1'b0, 1'b1, 4'b0010);
      tick();
      req_valid_i[1] = 1'b0;
      expect_out("pair_2a", 1'b1, 2'd2, 64'h3200, 1'b1, 1'b0, 4'b0100);
      tick();
      set_req(2, 1'b1, 64'h3201, 1'b1);
      expect_out("pair_2b", 1'b1, 2'd2, 64'h3201, 1'b0, 1'b1, 4'b0100);
      tick();
      req_valid_i = '0;

      // Req3 locked, stalled 3 cycles on beat 2 while req0 waits.
      set_req(3, 1'b1, 64'h4300, 1'b0);
      set_req(0, 1'b1, 64'h4000, 1'b1);
      expect_out("lock3_b0", 1'b1, 2'd3, 64'h4300, 1'b1, 1'b0, 4'b1000);
      tick();
      set_req(3, 1'b1, 64'h4301, 1'b0);
      expect_out("lock3_b1", 1'b1, 2'd3, 64'h4301, 1'b0, 1'b0, 4'b1000);
      tick();
      set_req(3, 1'b1, 64'h4302, 1'b0);
      out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_out("lock3_stall", 1'b1, 2'd3, 64'h4302, 1'b0, 1'b0, 4'b0000);
         tick();
      end
      out_ready_i = 1'b1;
      expect_out("lock3_b2", 1'b1, 2'd3, 64'h4302, 1'b0, 1'b0, 4'b1000);
      tick();
      set_req(3, 1'b1, 64'h4303, 1'b1);
      expect_out("lock3_b3", 1'b1, 2'd3, 64'h4303, 1'b0, 1'b1, 4'b1000);
      tick();
      req_valid_i[3] = 1'b0;
      expect_out("after3", 1'b1, 2'd0, 64'h4000, 1'b1, 1'b1, 4'b0001);
      tick();
      req_valid_i = '0;

      // Req2 locked, bubbles 2 cycles while req1 waits, then finishes first.
      set_req(2, 1'b1, 64'h5200, 1'b0);
      expect_out("bub_b0", 1'b1, 2'd2, 64'h5200, 1'b1, 1'b0, 4'b0100);
      tick();
      req_valid_i[2] = 1'b0;
      set_req(1, 1'b1, 64'h5100, 1'b1);
      for (int i = 0; i < 2; i++) begin
         expect_out("bubble", 1'b0, 2'd2, 64'h5200, 1'b0, 1'b0, 4'b0000);
         tick();
      end
      set_req(2, 1'b1, 64'h5201, 1'b1);
      expect_out("bub_b1", 1'b1, 2'd2, 64'h5201, 1'b0, 1'b1, 4'b0100);
      tick();
      req_valid_i[2] = 1'b0;
      expect_out("bub_next", 1'b1, 2'd1, 64'h5100, 1'b1, 1'b1, 4'b0010);
      tick();
      req_valid_i = '0;

      // Reset during beat 2 of a req1 burst; afterwards req0 wins fresh.
      set_req(1, 1'b1, 64'h6100, 1'b0);
      expect_out("rb_b0", 1'b1, 2'd1, 64'h6100, 1'b1, 1'b0, 4'b0010);
      tick();
      set_req(1, 1'b1, 64'h6101, 1'b0);
      expect_out("rb_b1", 1'b1, 2'd1, 64'h6101, 1'b0, 1'b0, 4'b0010);
      tick();
      set_req(1, 1'b1, 64'h6102, 1'b0);
      rst_i = 1'b1;
      expect_out("rst_mid", 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 4'b0000);
      tick();
      expect_out("rst_hold", 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 4'b0000);
      rst_i = 1'b0;
      set_req(0, 1'b1, 64'h6000, 1'b1);
      expect_out("post_rst", 1'b1, 2'd0, 64'h6000, 1'b1, 1'b1, 4'b0001);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
